mem_wb_pipe_reg_n: RTL

Parametrised MEM/WB pipeline stage for an N-issue pipeline. Replaces the fixed dual-lane MEM/WB latch with a valid/ready stage backed by a 2-entry skid buffer. Per lane it carries the destination register, write data, flag values and flag-write signals. Adds synchronous flush and in-stage resolution of same-bundle write-after-write conflicts. Sits between the MEM stage and the register-file/flag write port.

---
 rtl/mem_wb_pipe_reg_n.sv | 138 +++++++++++++
 1 files changed

// File: rtl/mem_wb_pipe_reg_n.sv
// MEM/WB stage for an N-issue pipeline: valid/ready handshake, 2-entry skid, flush, in-stage WAW resolution.
// Optional MEM_WB_STATS_EN adds saturating stall_cnt / flush_cnt outputs.
`timescale 1ns/1ps
module mem_wb_pipe_reg_n #(
    parameter int LANES  = 2,
    parameter int DATA_W = 32,
    parameter int RD_W   = 3,
    parameter int FLAG_W = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [LANES-1:0]           in_regWrite,
    input  logic [LANES*RD_W-1:0]      in_rd,
    input  logic [LANES*DATA_W-1:0]    in_data,
    input  logic [LANES*FLAG_W-1:0]    in_flag,
    input  logic [LANES*FLAG_W-1:0]    in_flag_we,
`ifdef MEM_WB_STATS_EN
    output logic [15:0]                stall_cnt,
    output logic [15:0]                flush_cnt,
`endif
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [LANES-1:0]           out_regWrite,
    output logic [LANES*RD_W-1:0]      out_rd,
    output logic [LANES*DATA_W-1:0]    out_data,
    output logic [LANES*FLAG_W-1:0]    out_flag,
    output logic [LANES*FLAG_W-1:0]    out_flag_we
);
    // Stored bundle layout, LSB first: regWrite, rd, data, flag, flag_we.
    localparam int RD_LO   = LANES;
    localparam int DATA_LO = RD_LO + LANES * RD_W;
    localparam int FLAG_LO = DATA_LO + LANES * DATA_W;
    localparam int FW_LO   = FLAG_LO + LANES * FLAG_W;
    localparam int PW      = FW_LO + LANES * FLAG_W;

    logic [LANES-1:0]        rw_res;
    logic [LANES*FLAG_W-1:0] fw_res;
    logic [PW-1:0]           in_pay;

    logic          main_valid_q, main_valid_d;
    logic          skid_valid_q, skid_valid_d;
    logic [PW-1:0] main_pay_q, main_pay_d;
    logic [PW-1:0] skid_pay_q, skid_pay_d;

    logic accept;
    logic drain;

    // Younger lanes (higher index) win; older lanes lose conflicting write enables.
    for (genvar gi = 0; gi < LANES; gi++) begin : g_waw
        logic              rw_kill;
        logic [FLAG_W-1:0] fw_kill;
        always_comb begin
            rw_kill = 1'b0;
            fw_kill = '0;
            for (int j = gi + 1; j < LANES; j++) begin
                if (in_regWrite[j] && (in_rd[j*RD_W +: RD_W] == in_rd[gi*RD_W +: RD_W]))
                    rw_kill = 1'b1;
                fw_kill = fw_kill | in_flag_we[j*FLAG_W +: FLAG_W];
            end
        end
        assign rw_res[gi] = in_regWrite[gi] & ~rw_kill;
        assign fw_res[gi*FLAG_W +: FLAG_W] = in_flag_we[gi*FLAG_W +: FLAG_W] & ~fw_kill;
    end

    assign in_pay = {fw_res, in_flag, in_data, in_rd, rw_res};
    assign accept = in_valid && in_ready;
    assign drain  = main_valid_q && out_ready;

    always_comb begin
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        main_pay_d   = main_pay_q;
        skid_pay_d   = skid_pay_q;
        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!main_valid_q || drain) begin
            if (skid_valid_q) begin
                main_valid_d = 1'b1;
                main_pay_d   = skid_pay_q;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                main_valid_d = 1'b1;
                main_pay_d   = in_pay;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_valid_d = 1'b1;
            skid_pay_d   = in_pay;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            main_pay_q   <= '0;
            skid_pay_q   <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            main_pay_q   <= main_pay_d;
            skid_pay_q   <= skid_pay_d;
        end
    end

    assign in_ready     = !skid_valid_q;
    assign out_valid    = main_valid_q;
    assign out_regWrite = main_pay_q[0 +: LANES] & {LANES{main_valid_q}};
    assign out_rd       = main_pay_q[RD_LO +: LANES*RD_W];
    assign out_data     = main_pay_q[DATA_LO +: LANES*DATA_W];
    assign out_flag     = main_pay_q[FLAG_LO +: LANES*FLAG_W];
    assign out_flag_we  = main_pay_q[FW_LO +: LANES*FLAG_W] & {(LANES*FLAG_W){main_valid_q}};

`ifdef MEM_WB_STATS_EN
    logic [15:0] stall_cnt_q;
    logic [15:0] flush_cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (main_valid_q && !out_ready && (stall_cnt_q != 16'hFFFF))
                stall_cnt_q <= stall_cnt_q + 16'd1;
            if (flush && (main_valid_q || skid_valid_q) && (flush_cnt_q != 16'hFFFF))
                flush_cnt_q <= flush_cnt_q + 16'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif
endmodule
